// File: rtl/ccd_line_timing_gen.sv
// Linear-CCD line timing generator: SH, P1/P2, RS, CP clocks plus per-pixel ADC strobe.
// Optional clamp pulse generation on ccd_cp when CCD_CLAMP_EN is defined (otherwise ccd_cp is held 0).
module ccd_line_timing_gen #(
    parameter int unsigned PIXELS     = 2048,
    parameter int unsigned DUMMY_PIX  = 32,
    parameter int unsigned HALF       = 50,
    parameter int unsigned RS_W       = 5,
    parameter int unsigned CP_W       = 10,
    parameter int unsigned SAMPLE_OFS = 80,
    parameter int unsigned SETUP_CLKS = 100,
    parameter int unsigned SH_W       = 200,
    parameter int unsigned HOLD_CLKS  = 100
) (
    input  logic        clk_100M,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] int_time,
    input  logic        abort,
    output logic        ready,
    output logic        busy,
    output logic        ccd_p1,
    output logic        ccd_p2,
    output logic        ccd_sh,
    output logic        ccd_rs,
    output logic        ccd_cp,
    output logic        adc_start,
    output logic [(PIXELS > 1 ? $clog2(PIXELS) : 1)-1:0] pixel_idx,
    output logic        line_done
);

    localparam int unsigned PERIOD  = 2 * HALF;
    localparam int unsigned TOTAL   = DUMMY_PIX + PIXELS;
    localparam int unsigned PH_W    = $clog2(PERIOD);
    localparam int unsigned CP_END  = RS_W + CP_W;
    localparam int unsigned PHC_W   = $clog2((CP_END > PERIOD ? CP_END : PERIOD) + 1);
    localparam int unsigned PX_W    = $clog2(TOTAL + 1);
    localparam int unsigned PX1_W   = PX_W + 1;
    localparam int unsigned IDX_W   = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam int unsigned CNT_M1  = (SETUP_CLKS > SH_W) ? SETUP_CLKS : SH_W;
    localparam int unsigned CNT_MAX = (CNT_M1 > HOLD_CLKS) ? CNT_M1 : HOLD_CLKS;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SH,
        S_HOLD,
        S_READOUT,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [PH_W-1:0]    phase;
    logic [PX_W-1:0]    pix;
    logic [23:0]        timer;
    logic [23:0]        int_lat;

    logic               period_end;
    logic               last_period;
    logic [PH_W-1:0]    ro_ph;
    logic [PX_W-1:0]    ro_px;
    logic [PHC_W-1:0]   ph_ext;
    logic [23:0]        timer_inc;
    logic               timer_hit;
    logic               d_p1;
    logic               d_rs;
    logic               d_cp;
    logic               d_adc;
    logic [IDX_W-1:0]   d_idx;

    // Pixel clock decode for the cycle about to be entered (first pixel when leaving HOLD).
    always_comb begin
        period_end  = (phase == PH_W'(PERIOD - 1));
        last_period = period_end && (pix == PX_W'(TOTAL - 1));
        ro_ph       = '0;
        ro_px       = '0;
        if (state == S_READOUT) begin
            ro_ph = period_end ? '0 : phase + PH_W'(1);
            ro_px = period_end ? pix + PX_W'(1) : pix;
        end
        ph_ext    = PHC_W'(ro_ph);
        d_p1      = (ph_ext < PHC_W'(HALF));
        d_rs      = (ph_ext < PHC_W'(RS_W));
`ifdef CCD_CLAMP_EN
        d_cp      = (ph_ext >= PHC_W'(RS_W)) && (ph_ext < PHC_W'(CP_END));
`else
        d_cp      = 1'b0;
`endif
        d_adc     = (ph_ext == PHC_W'(SAMPLE_OFS)) &&
                    ((PX1_W'(ro_px) + PX1_W'(1)) > PX1_W'(DUMMY_PIX));
        d_idx     = IDX_W'(ro_px - PX_W'(DUMMY_PIX));
        timer_inc = (timer == 24'hFF_FFFF) ? timer : timer + 24'd1;
        timer_hit = (timer_inc >= int_lat);
    end

    // Line sequencer; every output is registered with the value for the state being entered.
    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            phase     <= '0;
            pix       <= '0;
            timer     <= '0;
            int_lat   <= '0;
            ready     <= 1'b1;
            busy      <= 1'b0;
            ccd_p1    <= 1'b1;
            ccd_p2    <= 1'b0;
            ccd_sh    <= 1'b0;
            ccd_rs    <= 1'b0;
            ccd_cp    <= 1'b0;
            adc_start <= 1'b0;
            pixel_idx <= '0;
            line_done <= 1'b0;
        end else begin
            adc_start <= 1'b0;
            line_done <= 1'b0;
            if (state != S_IDLE) begin
                timer <= timer_inc;
            end
            if (abort && (state != S_IDLE)) begin
                state     <= S_IDLE;
                cnt       <= '0;
                ready     <= 1'b1;
                busy      <= 1'b0;
                ccd_p1    <= 1'b1;
                ccd_p2    <= 1'b0;
                ccd_sh    <= 1'b0;
                ccd_rs    <= 1'b0;
                ccd_cp    <= 1'b0;
                pixel_idx <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state   <= S_SETUP;
                            int_lat <= int_time;
                            cnt     <= '0;
                            ready   <= 1'b0;
                            busy    <= 1'b1;
                        end
                    end
                    S_SETUP: begin
                        if (cnt == CNT_W'(SETUP_CLKS - 1)) begin
                            state  <= S_SH;
                            cnt    <= '0;
                            ccd_sh <= 1'b1;
                            timer  <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    S_SH: begin
                        if (cnt == CNT_W'(SH_W - 1)) begin
                            state  <= S_HOLD;
                            cnt    <= '0;
                            ccd_sh <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    S_HOLD: begin
                        if (cnt == CNT_W'(HOLD_CLKS - 1)) begin
                            state     <= S_READOUT;
                            cnt       <= '0;
                            phase     <= ro_ph;
                            pix       <= ro_px;
                            ccd_p1    <= d_p1;
                            ccd_p2    <= ~d_p1;
                            ccd_rs    <= d_rs;
                            ccd_cp    <= d_cp;
                            adc_start <= d_adc;
                            if (d_adc) begin
                                pixel_idx <= d_idx;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    S_READOUT: begin
                        if (last_period) begin
                            ccd_p1 <= 1'b1;
                            ccd_p2 <= 1'b0;
                            ccd_rs <= 1'b0;
                            ccd_cp <= 1'b0;
                            if (timer_hit) begin
                                state     <= S_DONE;
                                line_done <= 1'b1;
                            end else begin
                                state <= S_WAIT;
                            end
                        end else begin
                            phase     <= ro_ph;
                            pix       <= ro_px;
                            ccd_p1    <= d_p1;
                            ccd_p2    <= ~d_p1;
                            ccd_rs    <= d_rs;
                            ccd_cp    <= d_cp;
                            adc_start <= d_adc;
                            if (d_adc) begin
                                pixel_idx <= d_idx;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (timer_hit) begin
                            state     <= S_DONE;
                            line_done <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ccd_line_timing_gen.sv
// Scoreboard bench for ccd_line_timing_gen with a small geometry (8 active + 2 dummy pixels).
module tb_ccd_line_timing_gen;

    localparam int PIX  = 8;
    localparam int DUM  = 2;
    localparam int HF   = 4;
    localparam int RSW  = 1;
    localparam int CPW  = 2;
    localparam int SOFS = 6;
    localparam int SU   = 2;
    localparam int SHW  = 2;
    localparam int HLD  = 2;
    localparam int P    = 2 * HF;
    localparam int TOT  = PIX + DUM;
    localparam int R0   = 1 + SU + SHW + HLD;
    localparam int RO_LEN = TOT * P;

    logic        clk_100M;
    logic        rst;
    logic        start;
    logic [23:0] int_time;
    logic        abort;
    logic        ready;
    logic        busy;
    logic        ccd_p1;
    logic        ccd_p2;
    logic        ccd_sh;
    logic        ccd_rs;
    logic        ccd_cp;
    logic        adc_start;
    logic [2:0]  pixel_idx;
    logic        line_done;

    ccd_line_timing_gen #(
        .PIXELS(PIX), .DUMMY_PIX(DUM), .HALF(HF), .RS_W(RSW), .CP_W(CPW),
        .SAMPLE_OFS(SOFS), .SETUP_CLKS(SU), .SH_W(SHW), .HOLD_CLKS(HLD)
    ) dut (
        .clk_100M(clk_100M), .rst(rst), .start(start), .int_time(int_time), .abort(abort),
        .ready(ready), .busy(busy), .ccd_p1(ccd_p1), .ccd_p2(ccd_p2), .ccd_sh(ccd_sh),
        .ccd_rs(ccd_rs), .ccd_cp(ccd_cp), .adc_start(adc_start), .pixel_idx(pixel_idx),
        .line_done(line_done)
    );

    initial begin
        clk_100M = 1'b0;
        forever #5 clk_100M = ~clk_100M;
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk_100M) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    typedef struct {
        int t;
        int idx;
    } ev_t;

    ev_t adc_q[$];
    int  done_q[$];
    ev_t ev;
    ev_t ne;

    function automatic int done_rel(input int it);
        int a;
        int b;
        a = R0 + RO_LEN;
        b = 1 + SU + it;
        return (a > b) ? a : b;
    endfunction

    // Reference state of the line in progress
    int t0 = 0;
    int line_end = -1;
    int dn_rel = 0;
    int c, rel, ph, px;
    bit busy_e, p1_e, sh_e, rs_e, cp_e, adc_e, ld_e;

    always @(negedge clk_100M) begin
        c      = cyc;
        busy_e = !rst && (c >= t0 + 1) && (c <= line_end);
        rel    = c - t0;
        p1_e = 1'b1; sh_e = 1'b0; rs_e = 1'b0; cp_e = 1'b0; adc_e = 1'b0; ld_e = 1'b0;
        if (busy_e) begin
            sh_e = (rel >= 1 + SU) && (rel <= SU + SHW);
            ld_e = (rel == dn_rel);
            if (rel >= R0 && rel < R0 + RO_LEN) begin
                ph    = (rel - R0) % P;
                px    = (rel - R0) / P;
                p1_e  = (ph < HF);
                rs_e  = (ph < RSW);
`ifdef CCD_CLAMP_EN
                cp_e  = (ph >= RSW) && (ph < RSW + CPW);
`endif
                adc_e = (ph == SOFS) && (px >= DUM);
            end
        end
        check("ready", ready, !busy_e);
        check("busy", busy, busy_e);
        check("p1", ccd_p1, p1_e);
        check("p2", ccd_p2, !p1_e);
        check("sh", ccd_sh, sh_e);
        check("rs", ccd_rs, rs_e);
        check("cp", ccd_cp, cp_e);
        check("adc_start", adc_start, adc_e);
        check("line_done", line_done, ld_e);

        if (adc_start === 1'b1) begin
            if (adc_q.size() == 0) check("adc_unexpected", adc_q.size(), 1);
            else begin
                ev = adc_q.pop_front();
                check("adc_time", c, ev.t);
                check("adc_idx", pixel_idx, ev.idx);
            end
        end
        if (line_done === 1'b1) begin
            if (done_q.size() == 0) check("done_unexpected", done_q.size(), 1);
            else check("done_time", c, done_q.pop_front());
        end

        if (rst) begin
            line_end = c;
            adc_q.delete();
            done_q.delete();
        end else begin
            if (abort && busy_e) begin
                line_end = c;
                while (adc_q.size() > 0 && adc_q[$].t > c) adc_q.delete(adc_q.size() - 1);
                while (done_q.size() > 0 && done_q[$] > c) done_q.delete(done_q.size() - 1);
            end
            if (start && !busy_e) begin
                t0       = c;
                dn_rel   = done_rel(int'(int_time));
                line_end = c + dn_rel;
                for (int k = DUM; k < TOT; k++) begin
                    ne.t   = c + R0 + k * P + SOFS;
                    ne.idx = k - DUM;
                    adc_q.push_back(ne);
                end
                done_q.push_back(c + dn_rel);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_100M);
        #2;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        if (n >= budget) check("idle_timeout", ready, 1);
        tick(2);
    endtask

    task automatic run_line(input int it);
        int_time = 24'(it);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        int_time = 24'(it + 333);
        wait_idle(1500);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; int_time = '0;
        tick(3);
        rst = 1'b0;
        tick(3);

        run_line(1000);
        run_line(0);
        run_line(120);
        run_line(84);
        run_line(85);

        // abort during the 5th pixel, then restart right away
        int_time = 24'd0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(R0 + 4 * P + 2 - 1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_idle(500);

        // abort alone in IDLE is ignored; abort with start in IDLE starts a line
        abort = 1'b1;
        tick(2);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        abort = 1'b0;
        wait_idle(500);

        // start held high: back-to-back lines, int_time changed mid-stream
        int_time = 24'd90;
        start = 1'b1;
        tick(150);
        int_time = 24'd20;
        tick(200);
        start = 1'b0;
        wait_idle(500);

        // reset in the middle of readout
        int_time = 24'd0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(R0 + 6 * P + 7 - 1);
        rst = 1'b1;
        #1;
        check("arst_ready", ready, 1);
        check("arst_busy", busy, 0);
        check("arst_p1", ccd_p1, 1);
        check("arst_p2", ccd_p2, 0);
        check("arst_sh", ccd_sh, 0);
        check("arst_rs", ccd_rs, 0);
        check("arst_cp", ccd_cp, 0);
        check("arst_adc", adc_start, 0);
        check("arst_idx", pixel_idx, 0);
        check("arst_done", line_done, 0);
        tick(2);
        rst = 1'b0;
        tick(2);
        check("post_rst_ready", ready, 1);

        run_line(10);
        tick(5);
        check("adc_left", adc_q.size(), 0);
        check("done_left", done_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
